// File: rtl/timer_responder.sv
// ============================================================================
//  Module   : timer_responder
//  Purpose  : Bus-mapped DIV/TIMA/TMA/TAC divider-timer with reload interrupt.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    inout  wire  [7:0]  databus,
    input  logic        RE,
    input  logic        WE,
    output logic        timer_irq
);

    localparam logic [1:0]       c_OFF_DIV  = 2'd0;
    localparam logic [1:0]       c_OFF_TIMA = 2'd1;
    localparam logic [1:0]       c_OFF_TMA  = 2'd2;
    localparam logic [1:0]       c_OFF_TAC  = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_RELOAD = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tima;
    logic [7:0]       r_tma;
    logic [2:0]       r_tac;
    logic             r_tbit_q;

    logic [15:0] w_offset;
    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_div;
    logic        w_wr_tima;
    logic        w_wr_tma;
    logic        w_wr_tac;
    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic        w_tbit;
    logic        w_tick;

    // Unsigned offset from the base: in range iff the upper 14 bits are zero.
    assign w_offset  = address - BASE_ADDR;
    assign w_sel     = (RE | WE) && (w_offset[15:2] == 14'd0);
    assign w_wr      = WE && w_sel;
    assign w_rd      = RE && w_sel && !WE;
    assign w_wr_div  = w_wr && (w_offset[1:0] == c_OFF_DIV);
    assign w_wr_tima = w_wr && (w_offset[1:0] == c_OFF_TIMA);
    assign w_wr_tma  = w_wr && (w_offset[1:0] == c_OFF_TMA);
    assign w_wr_tac  = w_wr && (w_offset[1:0] == c_OFF_TAC);
    assign w_wdata   = databus;

    always_comb begin
        w_rdata = 8'h00;
        case (w_offset[1:0])
            c_OFF_DIV:  w_rdata = r_cnt[15:8];
            c_OFF_TIMA: w_rdata = r_tima;
            c_OFF_TMA:  w_rdata = r_tma;
            default:    w_rdata = {5'b11111, r_tac};
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;

    always_comb begin
        w_tbit = 1'b0;
        case (r_tac[1:0])
            2'b00:   w_tbit = r_cnt[9];
            2'b01:   w_tbit = r_cnt[3];
            2'b10:   w_tbit = r_cnt[5];
            default: w_tbit = r_cnt[7];
        endcase
        w_tbit = w_tbit & r_tac[2];
    end

    // Falling edge of the selected bit; also fires on DIV-clear / TAC glitches.
    assign w_tick = r_tbit_q & ~w_tbit;

    // A TIMA write in the reload cycle cancels the interrupt.
    assign timer_irq = (r_state == S_RELOAD) && !w_wr_tima;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_tbit_q <= 1'b0;
            r_tma    <= 8'h00;
            r_tac    <= 3'b000;
        end else begin
            r_cnt    <= w_wr_div ? '0 : r_cnt + c_CNT_ONE;
            r_tbit_q <= w_tbit;
            if (w_wr_tma) begin
                r_tma <= w_wdata;
            end
            if (w_wr_tac) begin
                r_tac <= w_wdata[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_tima  <= 8'h00;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_wr_tima) begin
                        r_tima <= w_wdata;
                    end else if (w_tick) begin
                        if (r_tima == 8'hFF) begin
                            r_tima  <= 8'h00;
                            r_state <= S_RELOAD;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                default: begin
                    // Ticks are ignored here; a TMA write in this cycle is forwarded.
                    if (w_wr_tima || w_wr_tma) begin
                        r_tima <= w_wdata;
                    end else begin
                        r_tima <= r_tma;
                    end
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_responder.sv
// ============================================================================
//  Module   : tb_timer_responder
//  Purpose  : Directed plus random bench for timer_responder with reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RE = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  drv = 8'h00;
    logic        drv_en = 1'b0;
    wire  [7:0]  databus;
    wire         timer_irq;

    assign databus = drv_en ? drv : 8'hzz;

    timer_responder #(.BASE_ADDR(16'hFF04), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .databus   (databus),
        .RE        (RE),
        .WE        (WE),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: plain integers following the timer rules.
    int   m_cnt, m_tima, m_tma, m_tac;
    bit   m_prev, m_reload;
    int   irq_count = 0;
    logic [7:0] last_rd;
    logic [7:0] zval = 8'hzz;
    int   c_bits[4] = '{9, 3, 5, 7};

    function automatic bit m_bit();
        return (((m_tac >> 2) & 1) == 1) && (((m_cnt >> c_bits[m_tac & 3]) & 1) == 1);
    endfunction

    function automatic logic [7:0] m_read(int off);
        case (off)
            0:       return 8'((m_cnt >> 8) & 255);
            1:       return 8'(m_tima);
            2:       return 8'(m_tma);
            default: return 8'(8'hF8 | m_tac);
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
        m_prev = 1'b0; m_reload = 1'b0;
    endtask

    task automatic model_step(bit wr, int off, int wd);
        bit tick, nb;
        nb   = m_bit();
        tick = m_prev && !nb;
        if (m_reload) begin
            m_reload = 1'b0;
            if (wr && (off == 1 || off == 2)) m_tima = wd;
            else                              m_tima = m_tma;
        end else if (wr && off == 1) begin
            m_tima = wd;
        end else if (tick) begin
            if (m_tima == 255) begin
                m_tima   = 0;
                m_reload = 1'b1;
            end else begin
                m_tima = m_tima + 1;
            end
        end
        m_cnt = (wr && off == 0) ? 0 : ((m_cnt + 1) & 16'hFFFF);
        if (wr && off == 2) m_tma = wd;
        if (wr && off == 3) m_tac = wd & 7;
        m_prev = nb;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after negedge, check reads and irq, then advance model.
    task automatic cyc(bit re, bit we, logic [15:0] addr, logic [7:0] wd, string tag);
        logic [15:0] offv;
        bit inr, exp_irq;
        @(negedge clk);
        RE = re; WE = we; address = addr; drv = wd; drv_en = we;
        #1;
        offv = addr - 16'hFF04;
        inr  = (offv < 16'd4);
        last_rd = databus;
        if (re && !we && inr) check(tag, databus, m_read(int'(offv)));
        if (!we && !(re && inr)) check({tag, "_z"}, databus, zval);
        exp_irq = m_reload && !(we && inr && offv == 16'd1);
        check({tag, "_irq"}, {7'b0, timer_irq}, {7'b0, exp_irq});
        if (timer_irq) irq_count++;
        @(posedge clk);
        model_step(we && inr, int'(offv), int'(wd));
        #1;
        RE = 1'b0; WE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic wait_reload(int max, string tag);
        int k = 0;
        while (!m_reload && k < max) begin
            cyc(1'b1, 1'b0, 16'hFF05, 8'h00, tag);
            k++;
        end
        check({tag, "_timeout"}, {7'b0, m_reload}, 8'h01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int irq0, tima_before;
        logic [15:0] a;
        bit re, we;

        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {7'b0, timer_irq}, 8'h00);
        rst_n = 1'b1;
        model_reset();

        // Reset values and bus release
        cyc(1, 0, 16'hFF04, 8'h00, "t1_div");  check("t1_div_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF05, 8'h00, "t1_tima"); check("t1_tima_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF06, 8'h00, "t1_tma");  check("t1_tma_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF07, 8'h00, "t1_tac");  check("t1_tac_c", last_rd, 8'hF8);
        cyc(0, 0, 16'hFF05, 8'h00, "t1_nore");
        cyc(1, 0, 16'hFF08, 8'h00, "t1_ff08");
        cyc(1, 0, 16'hFF03, 8'h00, "t1_ff03");

        // Period-16 counting
        cyc(0, 1, 16'hFF04, 8'h5A, "t2_div");
        cyc(0, 1, 16'hFF05, 8'h00, "t2_tima");
        cyc(0, 1, 16'hFF07, 8'h05, "t2_tac");
        repeat (160) cyc(0, 0, 16'h0000, 8'h00, "t2_idle");
        cyc(1, 0, 16'hFF05, 8'h00, "t2_tima_rd");
        check("t2_tima_ge9", {7'b0, (last_rd >= 8'h09 && last_rd <= 8'h0A)}, 8'h01);

        // Overflow and reload with irq
        cyc(0, 1, 16'hFF06, 8'hF0, "t3_tma");
        cyc(0, 1, 16'hFF05, 8'hFF, "t3_tima");
        irq0 = irq_count;
        wait_reload(40, "t3_wait");
        cyc(1, 0, 16'hFF05, 8'h00, "t3_rl");   check("t3_rl_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF05, 8'h00, "t3_post"); check("t3_post_c", last_rd, 8'hF0);
        check("t3_irqcnt", 8'(irq_count - irq0), 8'h01);

        // TIMA write cancels the reload
        cyc(0, 1, 16'hFF05, 8'hFF, "t4_tima");
        irq0 = irq_count;
        wait_reload(40, "t4_wait");
        cyc(0, 1, 16'hFF05, 8'h33, "t4_wr");
        cyc(1, 0, 16'hFF05, 8'h00, "t4_rd");   check("t4_rd_c", last_rd, 8'h33);
        check("t4_irqcnt", 8'(irq_count - irq0), 8'h00);

        // TMA write during reload is forwarded and irq still fires
        cyc(0, 1, 16'hFF05, 8'hFF, "t4b_tima");
        irq0 = irq_count;
        wait_reload(40, "t4b_wait");
        cyc(0, 1, 16'hFF06, 8'h77, "t4b_tma");
        cyc(1, 0, 16'hFF05, 8'h00, "t4b_rd");  check("t4b_rd_c", last_rd, 8'h77);
        check("t4b_irqcnt", 8'(irq_count - irq0), 8'h01);
        cyc(0, 1, 16'hFF05, 8'h33, "t4b_restore");

        // DIV write glitch tick on bit 9
        cyc(0, 1, 16'hFF07, 8'h04, "t5_tac");
        cyc(0, 1, 16'hFF04, 8'h00, "t5_div");
        for (int k = 0; k < 600 && m_cnt != 16'h0200; k++) cyc(0, 0, 16'h0000, 8'h00, "t5_idle");
        check("t5_reach", {7'b0, (m_cnt == 16'h0200)}, 8'h01);
        tima_before = m_tima;
        cyc(0, 1, 16'hFF04, 8'hC3, "t5_divwr");
        cyc(1, 0, 16'hFF04, 8'h00, "t5_divrd"); check("t5_div_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF05, 8'h00, "t5_tima");  check("t5_glitch", last_rd, 8'(tima_before + 1));

        // Randomised traffic, including RE&WE overlap and out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 16'hFF03;
                1:       a = 16'hFF08;
                default: a = 16'hFF04 + 16'($urandom_range(0, 3));
            endcase
            we = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 1) == 1);
            if (we && a == 16'hFF04 && $urandom_range(0, 3) != 0) we = 1'b0;
            cyc(re, we, a, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), "rnd");
        end

        // Reset during reload
        cyc(0, 1, 16'hFF07, 8'h05, "t6_tac");
        cyc(0, 1, 16'hFF06, 8'hAB, "t6_tma");
        cyc(0, 1, 16'hFF05, 8'hFF, "t6_tima");
        irq0 = irq_count;
        wait_reload(40, "t6_wait");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_irq_rst", {7'b0, timer_irq}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc(1, 0, 16'hFF04, 8'h00, "t6_div");  check("t6_div_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF05, 8'h00, "t6_tima"); check("t6_tima_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF06, 8'h00, "t6_tma");  check("t6_tma_c", last_rd, 8'h00);
        cyc(1, 0, 16'hFF07, 8'h00, "t6_tac");  check("t6_tac_c", last_rd, 8'hF8);
        repeat (4) cyc(0, 0, 16'h0000, 8'h00, "t6_idle");
        check("t6_irqcnt", 8'(irq_count - irq0), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
